// File: rtl/bf_pkg.sv
// Shared definitions for the Brainfuck program loader: opcodes, ASCII
// characters, error codes and the loader FSM state encoding.
package bf_pkg;

   // Core opcodes (3-bit)
   localparam logic [2:0] OP_NOP   = 3'b000;
   localparam logic [2:0] OP_INC   = 3'b010;
   localparam logic [2:0] OP_DEC   = 3'b011;
   localparam logic [2:0] OP_RIGHT = 3'b100;
   localparam logic [2:0] OP_LEFT  = 3'b101;
   localparam logic [2:0] OP_OPEN  = 3'b110;
   localparam logic [2:0] OP_CLOSE = 3'b111;

   // Source characters
   localparam logic [7:0] CH_PLUS  = 8'h2B;
   localparam logic [7:0] CH_MINUS = 8'h2D;
   localparam logic [7:0] CH_GT    = 8'h3E;
   localparam logic [7:0] CH_LT    = 8'h3C;
   localparam logic [7:0] CH_OPEN  = 8'h5B;
   localparam logic [7:0] CH_CLOSE = 8'h5D;
   localparam logic [7:0] CH_BANG  = 8'h21;
   localparam logic [7:0] CH_NUL   = 8'h00;

   // Error codes reported on o_error
   localparam logic [1:0] ERR_NONE      = 2'b00;
   localparam logic [1:0] ERR_OVERFLOW  = 2'b01;
   localparam logic [1:0] ERR_UNMATCHED = 2'b10;
   localparam logic [1:0] ERR_UNCLOSED  = 2'b11;

   // Loader FSM states
   typedef enum logic [1:0] {
      ST_CLEAR = 2'b00,
      ST_LOAD  = 2'b01,
      ST_DONE  = 2'b10,
      ST_ERROR = 2'b11
   } bf_state_e;

endpackage

// File: rtl/bf_char_decoder.sv
// Combinational translation of one source byte into
// {is_cmd, is_term, opcode}. Comment bytes decode to neither.
module bf_char_decoder
   import bf_pkg::*;
(
   input  logic [7:0] rx_byte,
   output logic       is_cmd,
   output logic       is_term,
   output logic [2:0] opcode
);

   // Byte classification and opcode lookup
   always_comb begin
      is_cmd  = 1'b0;
      is_term = 1'b0;
      opcode  = OP_NOP;
      case (rx_byte)
         CH_PLUS:  begin is_cmd = 1'b1; opcode = OP_INC;   end
         CH_MINUS: begin is_cmd = 1'b1; opcode = OP_DEC;   end
         CH_GT:    begin is_cmd = 1'b1; opcode = OP_RIGHT; end
         CH_LT:    begin is_cmd = 1'b1; opcode = OP_LEFT;  end
         CH_OPEN:  begin is_cmd = 1'b1; opcode = OP_OPEN;  end
         CH_CLOSE: begin is_cmd = 1'b1; opcode = OP_CLOSE; end
         CH_BANG,
         CH_NUL:   is_term = 1'b1;
         default:  ;
      endcase
   end

endmodule

// File: rtl/bf_program_loader.sv
// Program loader: clears program memory, then streams ASCII Brainfuck
// source in over a valid/ready port, writing one opcode per command byte.
// The core is held in reset until a terminator completes a valid program.
//
// Handshake: a byte transfers on a rising edge where i_rx_valid and
// o_rx_ready are both high; o_rx_ready is registered and never depends
// on i_rx_valid in the same cycle.
//
// Build option: define BF_BRACKET_CHECK_EN to track bracket depth and
// report unmatched ']' (10) and unclosed/over-deep '[' (11). Without it
// brackets are written blindly and only overflow (01) can occur.
// o_state exposes the FSM state for debug.
module bf_program_loader
   import bf_pkg::*;
#(
   parameter int PRGMEM_ADDR_WIDTH = 8,
   parameter int INSTR_WIDTH       = 3,
   parameter int DEPTH_WIDTH       = 4
) (
   input  logic                         i_clock,
   input  logic                         i_reset,
   input  logic [7:0]                   i_rx_data,
   input  logic                         i_rx_valid,
   output logic                         o_rx_ready,
   input  logic                         i_reload,
   output logic                         o_prgmem_we,
   output logic [PRGMEM_ADDR_WIDTH-1:0] o_prgmem_addr,
   output logic [INSTR_WIDTH-1:0]       o_prgmem_data,
   output logic                         o_core_reset,
   output logic                         o_done,
   output logic [1:0]                   o_error,
   output logic [PRGMEM_ADDR_WIDTH:0]   o_prog_len,
   output logic [1:0]                   o_state
);

   localparam int W = PRGMEM_ADDR_WIDTH;

   bf_state_e      state;
   logic [W-1:0]   clr_ptr;
   logic           dec_is_cmd;
   logic           dec_is_term;
   logic [2:0]     dec_opcode;
   logic           accept;

`ifdef BF_BRACKET_CHECK_EN
   logic [DEPTH_WIDTH-1:0] depth;
`else
   logic unused_depth_cfg;
   assign unused_depth_cfg = (DEPTH_WIDTH != 0);
`endif

   bf_char_decoder u_dec (
      .rx_byte (i_rx_data),
      .is_cmd  (dec_is_cmd),
      .is_term (dec_is_term),
      .opcode  (dec_opcode)
   );

   assign accept  = i_rx_valid && o_rx_ready;
   assign o_state = state;

   // Loader FSM with registered memory-write and status outputs
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state         <= ST_CLEAR;
         clr_ptr       <= '0;
         o_prgmem_we   <= 1'b0;
         o_prgmem_addr <= '0;
         o_prgmem_data <= '0;
         o_rx_ready    <= 1'b0;
         o_core_reset  <= 1'b1;
         o_done        <= 1'b0;
         o_error       <= ERR_NONE;
         o_prog_len    <= '0;
`ifdef BF_BRACKET_CHECK_EN
         depth         <= '0;
`endif
      end else begin
         case (state)
            // One NOP write per cycle; the last address hands over to LOAD
            ST_CLEAR: begin
               o_prgmem_we   <= 1'b1;
               o_prgmem_addr <= clr_ptr;
               o_prgmem_data <= '0;
               o_prog_len    <= '0;
               clr_ptr       <= clr_ptr + 1'b1;
               if (clr_ptr == '1) begin
                  state <= ST_LOAD;
               end
            end

            // Accept source bytes; terminator and error checks win over writes
            ST_LOAD: begin
               o_prgmem_we <= 1'b0;
               o_rx_ready  <= 1'b1;
               if (accept) begin
                  if (dec_is_term) begin
                     o_rx_ready <= 1'b0;
`ifdef BF_BRACKET_CHECK_EN
                     if (depth != '0) begin
                        state   <= ST_ERROR;
                        o_error <= ERR_UNCLOSED;
                     end else begin
                        state        <= ST_DONE;
                        o_done       <= 1'b1;
                        o_core_reset <= 1'b0;
                     end
`else
                     state        <= ST_DONE;
                     o_done       <= 1'b1;
                     o_core_reset <= 1'b0;
`endif
                  end else if (dec_is_cmd) begin
                     if (o_prog_len[W]) begin
                        // Memory already holds 2^W opcodes
                        state      <= ST_ERROR;
                        o_error    <= ERR_OVERFLOW;
                        o_rx_ready <= 1'b0;
`ifdef BF_BRACKET_CHECK_EN
                     end else if (dec_opcode == OP_CLOSE && depth == '0) begin
                        state      <= ST_ERROR;
                        o_error    <= ERR_UNMATCHED;
                        o_rx_ready <= 1'b0;
                     end else if (dec_opcode == OP_OPEN && depth == '1) begin
                        state      <= ST_ERROR;
                        o_error    <= ERR_UNCLOSED;
                        o_rx_ready <= 1'b0;
`endif
                     end else begin
                        o_prgmem_we   <= 1'b1;
                        o_prgmem_addr <= o_prog_len[W-1:0];
                        o_prgmem_data <= INSTR_WIDTH'(dec_opcode);
                        o_prog_len    <= o_prog_len + 1'b1;
`ifdef BF_BRACKET_CHECK_EN
                        if (dec_opcode == OP_OPEN) begin
                           depth <= depth + 1'b1;
                        end else if (dec_opcode == OP_CLOSE) begin
                           depth <= depth - 1'b1;
                        end
`endif
                     end
                  end
               end
            end

            // DONE and ERROR wait for a reload; the first clear write issues at once
            default: begin
               o_prgmem_we <= 1'b0;
               o_rx_ready  <= 1'b0;
               if (i_reload) begin
                  state         <= ST_CLEAR;
                  o_prgmem_we   <= 1'b1;
                  o_prgmem_addr <= '0;
                  o_prgmem_data <= '0;
                  clr_ptr       <= {{(W-1){1'b0}}, 1'b1};
                  o_core_reset  <= 1'b1;
                  o_done        <= 1'b0;
                  o_error       <= ERR_NONE;
                  o_prog_len    <= '0;
`ifdef BF_BRACKET_CHECK_EN
                  depth         <= '0;
`endif
               end
            end
         endcase
      end
   end

endmodule
